// File: rtl/lsensor_seq.sv
// Acquisition sequencer for G11620-class linear image sensors: loads run settings
// from the config RAM, then loops INTEG -> WAIT_SP -> DATA -> BLANK per frame.
module lsensor_seq #(
    parameter int PIX_NUM     = 512,
    parameter int PIX_W       = 16,
    parameter int FRAME_W     = 16,
    parameter int CFG_AW      = 8,
    parameter int CFG_RD_LAT  = 1,
    parameter int MODE_ADDR   = 0,
    parameter int INTEG_ADDR  = 1,
    parameter int FRAMES_ADDR = 2,
    parameter int BLANK_ADDR  = 3,
    parameter int SP_TIMEOUT  = 1024,
    parameter int DONE_CYC    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_in,
    input  logic               soft_reset_in,
    output logic               sensor_clk_o,
    output logic               sensor_reset_o,
    input  logic               ad_sp,
    output logic               cfg_ram_rd_o,
    output logic [CFG_AW-1:0]  cfg_ram_addr_o,
    input  logic [31:0]        cfg_ram_din,
    output logic               pix_valid_o,
    output logic [PIX_W-1:0]   pix_idx_o,
    output logic [FRAME_W-1:0] frame_idx_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_INTEG, S_WAIT_SP, S_DATA, S_BLANK, S_DONE
    } state_t;

    localparam logic [PIX_W-1:0] LAST_PIX  = PIX_W'(PIX_NUM - 1);
    localparam logic [2:0]       RD_LAT    = 3'(CFG_RD_LAT);
    localparam logic [31:0]      SP_LAST   = 32'(SP_TIMEOUT - 1);
    localparam logic [31:0]      DONE_LAST = 32'(DONE_CYC - 1);

    state_t               r_state;
    logic                 r_start_d;
    logic [1:0]           r_cfg_sel;
    logic [2:0]           r_lat_cnt;
    logic [31:0]          r_cnt;
    logic                 r_mode;
    logic [31:0]          r_integ;
    logic [31:0]          r_frames;
    logic [15:0]          r_blank;
    logic                 r_rd;
    logic [CFG_AW-1:0]    r_addr;
    logic                 r_sreset;
    logic                 r_valid;
    logic [PIX_W-1:0]     r_pix;
    logic [FRAME_W-1:0]   r_frame;
    logic                 r_done;
    logic                 r_timeout;

    logic                 w_start_edge;
    logic                 w_last_frame;
    logic                 w_blank_last;

    function automatic logic [31:0] nz_one(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

    function automatic logic [15:0] nz_blank(input logic [15:0] v);
        return (v == 16'd0) ? 16'd24 : v;
    endfunction

    function automatic logic [CFG_AW-1:0] cfg_addr(input logic [1:0] sel);
        case (sel)
            2'd0:    return CFG_AW'(MODE_ADDR);
            2'd1:    return CFG_AW'(INTEG_ADDR);
            2'd2:    return CFG_AW'(FRAMES_ADDR);
            default: return CFG_AW'(BLANK_ADDR);
        endcase
    endfunction

    assign w_start_edge = start_in & ~r_start_d;
    assign w_last_frame = (32'(r_frame) == (r_frames - 32'd1));
    assign w_blank_last = (r_cnt == ({16'd0, r_blank} - 32'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_start_d <= 1'b0;
            r_cfg_sel <= 2'd0;
            r_lat_cnt <= 3'd0;
            r_cnt     <= 32'd0;
            r_mode    <= 1'b0;
            r_integ   <= 32'd0;
            r_frames  <= 32'd0;
            r_blank   <= 16'd0;
            r_rd      <= 1'b0;
            r_addr    <= '0;
            r_sreset  <= 1'b0;
            r_valid   <= 1'b0;
            r_pix     <= '0;
            r_frame   <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_start_d <= start_in;
            if (soft_reset_in && (r_state != S_IDLE)) begin
                // Abort drops every strobe at once; an in-flight config read is simply never sampled.
                r_state   <= S_IDLE;
                r_rd      <= 1'b0;
                r_sreset  <= 1'b0;
                r_valid   <= 1'b0;
                r_done    <= 1'b0;
                r_pix     <= '0;
                r_cnt     <= 32'd0;
                r_lat_cnt <= 3'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start_edge && !soft_reset_in) begin
                            r_timeout <= 1'b0;
                            r_frame   <= '0;
                            r_cfg_sel <= 2'd0;
                            r_lat_cnt <= 3'd0;
                            r_rd      <= 1'b1;
                            r_addr    <= cfg_addr(2'd0);
                            r_state   <= S_CFG;
                        end
                    end
                    S_CFG: begin
                        r_rd <= 1'b0;
                        if (r_lat_cnt == RD_LAT) begin
                            r_lat_cnt <= 3'd0;
                            case (r_cfg_sel)
                                2'd0:    r_mode   <= cfg_ram_din[0];
                                2'd1:    r_integ  <= nz_one(cfg_ram_din);
                                2'd2:    r_frames <= nz_one(cfg_ram_din);
                                default: r_blank  <= nz_blank(cfg_ram_din[15:0]);
                            endcase
                            if (r_cfg_sel == 2'd3) begin
                                r_state  <= S_INTEG;
                                r_sreset <= 1'b1;
                                r_cnt    <= 32'd1;
                            end else begin
                                r_cfg_sel <= r_cfg_sel + 2'd1;
                                r_rd      <= 1'b1;
                                r_addr    <= cfg_addr(r_cfg_sel + 2'd1);
                            end
                        end else begin
                            r_lat_cnt <= r_lat_cnt + 3'd1;
                        end
                    end
                    S_INTEG: begin
                        // r_cnt counts the high cycles of sensor_reset_o starting at 1.
                        if (r_cnt == r_integ) begin
                            r_sreset <= 1'b0;
                            r_cnt    <= 32'd0;
                            r_state  <= S_WAIT_SP;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    S_WAIT_SP: begin
                        if (ad_sp) begin
                            r_valid <= 1'b1;
                            r_pix   <= '0;
                            r_state <= S_DATA;
                        end else if (r_cnt == SP_LAST) begin
                            r_timeout <= 1'b1;
                            r_done    <= 1'b1;
                            r_cnt     <= 32'd0;
                            r_state   <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    S_DATA: begin
                        if (r_pix == LAST_PIX) begin
                            r_valid <= 1'b0;
                            r_pix   <= '0;
                            r_cnt   <= 32'd0;
                            r_state <= S_BLANK;
                        end else begin
                            r_pix <= r_pix + PIX_W'(1);
                        end
                    end
                    S_BLANK: begin
                        if (w_blank_last) begin
                            if (r_mode ? !start_in : w_last_frame) begin
                                r_done  <= 1'b1;
                                r_cnt   <= 32'd0;
                                r_state <= S_DONE;
                            end else begin
                                r_frame  <= r_frame + FRAME_W'(1);
                                r_sreset <= 1'b1;
                                r_cnt    <= 32'd1;
                                r_state  <= S_INTEG;
                            end
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    S_DONE: begin
                        if (r_cnt == DONE_LAST) begin
                            r_done  <= 1'b0;
                            r_cnt   <= 32'd0;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign sensor_clk_o   = ~clk;
    assign sensor_reset_o = r_sreset;
    assign cfg_ram_rd_o   = r_rd;
    assign cfg_ram_addr_o = r_addr;
    assign pix_valid_o    = r_valid;
    assign pix_idx_o      = r_pix;
    assign frame_idx_o    = r_frame;
    assign busy_o         = (r_state != S_IDLE);
    assign done_o         = r_done;
    assign timeout_o      = r_timeout;

endmodule

// File: tb/tb_lsensor_seq.sv
// Bench for lsensor_seq: two instances (config read latency 1 and 3) share stimulus;
// per-run statistics are gathered by a monitor and compared with hand-computed tables.
module tb_lsensor_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_in;
    logic        soft_reset_in;

    logic        sensor_clk[2];
    logic        sreset[2];
    logic        ad_sp[2];
    logic        rd[2];
    logic [7:0]  addr[2];
    logic [31:0] din[2];
    logic        valid[2];
    logic [15:0] pix[2];
    logic [15:0] frame[2];
    logic        busy[2];
    logic        done[2];
    logic        tmo[2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        lsensor_seq #(.CFG_RD_LAT(g == 0 ? 1 : 3)) u_dut (
            .clk            (clk),
            .rst            (rst),
            .start_in       (start_in),
            .soft_reset_in  (soft_reset_in),
            .sensor_clk_o   (sensor_clk[g]),
            .sensor_reset_o (sreset[g]),
            .ad_sp          (ad_sp[g]),
            .cfg_ram_rd_o   (rd[g]),
            .cfg_ram_addr_o (addr[g]),
            .cfg_ram_din    (din[g]),
            .pix_valid_o    (valid[g]),
            .pix_idx_o      (pix[g]),
            .frame_idx_o    (frame[g]),
            .busy_o         (busy[g]),
            .done_o         (done[g]),
            .timeout_o      (tmo[g])
        );
    end

    // Config RAM: data appears CFG_RD_LAT cycles after the read strobe, garbage otherwise.
    logic [31:0] cfg_mem[4];
    logic [31:0] pipe0[4];
    logic [31:0] pipe1[4];
    assign din[0] = pipe0[0];
    assign din[1] = pipe1[2];

    always @(posedge clk) begin
        pipe0[0] <= rd[0] ? cfg_mem[addr[0][1:0]] : 32'hDEADBEEF;
        pipe1[0] <= rd[1] ? cfg_mem[addr[1][1:0]] : 32'hDEADBEEF;
        for (int i = 1; i < 4; i++) begin
            pipe0[i] <= pipe0[i-1];
            pipe1[i] <= pipe1[i-1];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Sensor model: one-cycle AD start pulse sp_delay cycles into WAIT_SP.
    bit sp_en;
    int sp_delay;
    bit armed[2];
    int wcnt[2];
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            ad_sp[k] = 1'b0;
            if (sreset[k]) begin
                armed[k] = 1'b1;
                wcnt[k]  = 0;
            end else if (armed[k]) begin
                if (wcnt[k] == sp_delay) begin
                    ad_sp[k] = sp_en;
                    armed[k] = 1'b0;
                end else begin
                    wcnt[k]++;
                end
            end
        end
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Monitor statistics, reset whenever run_id changes.
    int run_id = 0;
    int seen_id = 0;
    int n_rd[2], last_rd[2], rd_sp_err[2], rd_addr_err[2];
    int n_str[2], idx_err[2], frame_err[2], n_frames[2], exp_idx[2];
    int cur_int[2], integ_len[2], n_integ[2], gap_cnt[2], gap_len[2];
    int blank_cnt[2], blank_len[2], cur_done[2], done_len[2], n_done[2];
    bit in_gap[2], in_blank[2], p_sr[2], p_valid[2], p_done[2];

    always @(negedge clk) begin
        if (run_id != seen_id) begin
            seen_id = run_id;
            for (int k = 0; k < 2; k++) begin
                n_rd[k] = 0; last_rd[k] = 0; rd_sp_err[k] = 0; rd_addr_err[k] = 0;
                n_str[k] = 0; idx_err[k] = 0; frame_err[k] = 0; n_frames[k] = 0; exp_idx[k] = 0;
                cur_int[k] = 0; integ_len[k] = 0; n_integ[k] = 0; gap_cnt[k] = 0; gap_len[k] = 0;
                blank_cnt[k] = 0; blank_len[k] = 0; cur_done[k] = 0; done_len[k] = 0; n_done[k] = 0;
                in_gap[k] = 1'b0; in_blank[k] = 1'b0;
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (rd[k]) begin
                if (n_rd[k] > 0 && (cyc - last_rd[k]) != lat_of(k) + 1) rd_sp_err[k]++;
                if (int'(addr[k]) != n_rd[k]) rd_addr_err[k]++;
                last_rd[k] = cyc;
                n_rd[k]++;
            end
            if (sreset[k]) begin
                cur_int[k]++;
            end else if (p_sr[k]) begin
                integ_len[k] = cur_int[k];
                cur_int[k]   = 0;
                n_integ[k]++;
                in_gap[k]    = 1'b1;
                gap_cnt[k]   = 0;
            end
            if (in_gap[k]) begin
                if (valid[k] || done[k] || !busy[k]) begin
                    gap_len[k] = gap_cnt[k];
                    in_gap[k]  = 1'b0;
                end else begin
                    gap_cnt[k]++;
                end
            end
            if (valid[k]) begin
                if (!p_valid[k]) begin
                    exp_idx[k] = 0;
                    n_frames[k]++;
                    if (int'(frame[k]) != n_frames[k] - 1) frame_err[k]++;
                end
                if (int'(pix[k]) != exp_idx[k]) idx_err[k]++;
                exp_idx[k]++;
                n_str[k]++;
            end else if (p_valid[k]) begin
                in_blank[k]  = 1'b1;
                blank_cnt[k] = 0;
            end
            if (in_blank[k]) begin
                if (sreset[k] || done[k] || !busy[k]) begin
                    blank_len[k] = blank_cnt[k];
                    in_blank[k]  = 1'b0;
                end else begin
                    blank_cnt[k]++;
                end
            end
            if (done[k]) begin
                cur_done[k]++;
            end else if (p_done[k]) begin
                done_len[k] = cur_done[k];
                cur_done[k] = 0;
                n_done[k]++;
            end
            p_sr[k]    = sreset[k];
            p_valid[k] = valid[k];
            p_done[k]  = done[k];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic launch(input logic [31:0] m, input logic [31:0] i, input logic [31:0] f,
                          input logic [31:0] b, input bit cont);
        @(negedge clk); #1;
        cfg_mem[0] = m;
        cfg_mem[1] = i;
        cfg_mem[2] = f;
        cfg_mem[3] = b;
        run_id++;
        start_in = 1'b1;
        @(negedge clk); #1;
        if (!cont) begin
            @(negedge clk); #1;
            start_in = 1'b0;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy[0] || busy[1]) && n < 20000) begin
            @(negedge clk); #1;
            n++;
        end
        chk({tag, ".idle_wait"}, int'(n >= 20000), 0);
    endtask

    typedef struct {
        logic [31:0] mode;
        logic [31:0] integ;
        logic [31:0] frames;
        logic [31:0] blank;
        bit          sp_en;
        int          sp_delay;
        int          e_frames;
        int          e_str;
        int          e_integ;
        int          e_nint;
        int          e_blank;
        int          e_gap;
        bit          e_tmo;
        int          e_last;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, expected summary before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        start_in      = 1'b0;
        soft_reset_in = 1'b0;
        sp_en         = 1'b1;
        sp_delay      = 5;
        for (int i = 0; i < 4; i++) cfg_mem[i] = 32'd0;

        //        mode          integ   frames  blank           en    dly frm str   int nint blk gap   tmo  last
        vecs[0] = '{32'd0,        32'd10, 32'd1, 32'd0,          1'b1, 5,  1,  512,  10, 1,   24, 6,    1'b0, 0};
        vecs[1] = '{32'd0,        32'd10, 32'd3, 32'd0,          1'b1, 5,  3,  1536, 10, 3,   24, 6,    1'b0, 2};
        vecs[2] = '{32'd0,        32'd4,  32'd1, 32'd0,          1'b0, 5,  0,  0,    4,  1,   0,  1024, 1'b1, 0};
        vecs[3] = '{32'd0,        32'd0,  32'd0, 32'd5,          1'b1, 0,  1,  512,  1,  1,   5,  1,    1'b0, 0};
        vecs[4] = '{32'd0,        32'd3,  32'd2, 32'd1,          1'b1, 2,  2,  1024, 3,  2,   1,  3,    1'b0, 1};
        vecs[5] = '{32'hFFFFFFFE, 32'd2,  32'd2, 32'h00010003,   1'b1, 1,  2,  1024, 2,  2,   3,  2,    1'b0, 1};

        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("d%0d.reset_ctl", k),
                int'({busy[k], sreset[k], valid[k], done[k], tmo[k], rd[k]}), 0);
            chk($sformatf("d%0d.reset_data", k), int'(addr[k]) + int'(pix[k]) + int'(frame[k]), 0);
            chk($sformatf("d%0d.sensor_clk_lo", k), int'(sensor_clk[k]), 1);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) chk($sformatf("d%0d.sensor_clk_hi", k), int'(sensor_clk[k]), 0);
        @(negedge clk); #1;
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            sp_en    = vecs[v].sp_en;
            sp_delay = vecs[v].sp_delay;
            launch(vecs[v].mode, vecs[v].integ, vecs[v].frames, vecs[v].blank, 1'b0);
            for (int k = 0; k < 2; k++) chk($sformatf("v%0d.d%0d.tmo_clear", v, k), int'(tmo[k]), 0);
            wait_idle($sformatf("v%0d", v));
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("v%0d.d%0d.reads", v, k), n_rd[k], 4);
                chk($sformatf("v%0d.d%0d.read_spacing_errs", v, k), rd_sp_err[k], 0);
                chk($sformatf("v%0d.d%0d.read_addr_errs", v, k), rd_addr_err[k], 0);
                chk($sformatf("v%0d.d%0d.integ_runs", v, k), n_integ[k], vecs[v].e_nint);
                chk($sformatf("v%0d.d%0d.integ_len", v, k), integ_len[k], vecs[v].e_integ);
                chk($sformatf("v%0d.d%0d.wait_sp_len", v, k), gap_len[k], vecs[v].e_gap);
                chk($sformatf("v%0d.d%0d.frames", v, k), n_frames[k], vecs[v].e_frames);
                chk($sformatf("v%0d.d%0d.strobes", v, k), n_str[k], vecs[v].e_str);
                chk($sformatf("v%0d.d%0d.pix_idx_errs", v, k), idx_err[k], 0);
                chk($sformatf("v%0d.d%0d.frame_idx_errs", v, k), frame_err[k], 0);
                chk($sformatf("v%0d.d%0d.blank_len", v, k), blank_len[k], vecs[v].e_blank);
                chk($sformatf("v%0d.d%0d.done_windows", v, k), n_done[k], 1);
                chk($sformatf("v%0d.d%0d.done_len", v, k), done_len[k], 32);
                chk($sformatf("v%0d.d%0d.timeout", v, k), int'(tmo[k]), int'(vecs[v].e_tmo));
                chk($sformatf("v%0d.d%0d.final_frame", v, k), int'(frame[k]), vecs[v].e_last);
            end
        end

        // Continuous mode: start held for five frames, dropped mid-DATA of frame 4.
        begin
            int n;
            sp_en    = 1'b1;
            sp_delay = 5;
            launch(32'd1, 32'd10, 32'd1, 32'd0, 1'b1);
            n = 0;
            while (!(n_frames[0] == 5 && valid[0] && pix[0] >= 16'd200) && n < 20000) begin
                @(negedge clk); #1;
                n++;
            end
            chk("cont.frame4_wait", int'(n >= 20000), 0);
            start_in = 1'b0;
            wait_idle("cont");
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("cont.d%0d.frames", k), n_frames[k], 5);
                chk($sformatf("cont.d%0d.strobes", k), n_str[k], 2560);
                chk($sformatf("cont.d%0d.frame_idx_errs", k), frame_err[k], 0);
                chk($sformatf("cont.d%0d.final_frame", k), int'(frame[k]), 4);
                chk($sformatf("cont.d%0d.done_windows", k), n_done[k], 1);
                chk($sformatf("cont.d%0d.blank_len", k), blank_len[k], 24);
            end
        end

        // Soft reset at pixel 100, then start edge coinciding with soft reset.
        begin
            int n;
            launch(32'd0, 32'd10, 32'd1, 32'd0, 1'b0);
            n = 0;
            while (!(valid[0] && pix[0] == 16'd100) && n < 5000) begin
                @(negedge clk); #1;
                n++;
            end
            chk("soft.pix100_wait", int'(n >= 5000), 0);
            soft_reset_in = 1'b1;
            @(negedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("soft.d%0d.busy", k), int'(busy[k]), 0);
                chk($sformatf("soft.d%0d.pix_valid", k), int'(valid[k]), 0);
                chk($sformatf("soft.d%0d.sensor_reset", k), int'(sreset[k]), 0);
            end
            chk("soft.d0.strobes", n_str[0], 101);
            soft_reset_in = 1'b0;
            repeat (40) @(negedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("soft.d%0d.done_windows", k), n_done[k], 0);
                chk($sformatf("soft.d%0d.done", k), int'(done[k]), 0);
            end
            start_in      = 1'b1;
            soft_reset_in = 1'b1;
            @(negedge clk); #1;
            for (int k = 0; k < 2; k++) chk($sformatf("soft_start.d%0d.busy", k), int'(busy[k]), 0);
            soft_reset_in = 1'b0;
            repeat (3) @(negedge clk);
            #1;
            for (int k = 0; k < 2; k++) chk($sformatf("soft_start.d%0d.busy_later", k), int'(busy[k]), 0);
            start_in = 1'b0;
        end

        // Asynchronous rst in the middle of a long integration.
        begin
            int n;
            launch(32'd0, 32'd100, 32'd1, 32'd0, 1'b0);
            n = 0;
            while (!(sreset[0] && cur_int[0] >= 20) && n < 1000) begin
                @(negedge clk); #1;
                n++;
            end
            chk("arst.integ_wait", int'(n >= 1000), 0);
            #2;
            rst = 1'b1;
            #1;
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("arst.d%0d.sensor_reset", k), int'(sreset[k]), 0);
                chk($sformatf("arst.d%0d.busy", k), int'(busy[k]), 0);
                chk($sformatf("arst.d%0d.cfg_addr", k), int'(addr[k]), 0);
            end
            @(negedge clk); #1;
            rst = 1'b0;
            repeat (5) @(negedge clk);
            #1;
            for (int k = 0; k < 2; k++) chk($sformatf("arst.d%0d.busy_after", k), int'(busy[k]), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
